// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out word serializer, MSB first, valid/ready input.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] shadow_q, shadow_d;
  logic             sout_q, sout_d;
  logic             svalid_q, svalid_d;
  logic             fstart_q, fstart_d;
  logic             last_bit;
  logic             xfer;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST);

  // Ready never looks at data_valid, so upstream may gate valid on ready safely.
  always_comb begin
`ifdef PISO_PARITY_EN
    data_ready = (state_q == S_IDLE) || (state_q == S_PARITY);
`else
    data_ready = (state_q == S_IDLE) || last_bit;
`endif
  end

  assign xfer = data_valid && data_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sout_d   = sout_q;
    svalid_d = svalid_q;
    fstart_d = fstart_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        fstart_d = 1'b0;
      end
      S_SHIFT: begin
        fstart_d = 1'b0;
        if (!last_bit) begin
          sout_d   = shadow_q[WIDTH-2];
          shadow_d = shadow_q << 1;
          cnt_d    = cnt_q + 1'b1;
        end else begin
`ifdef PISO_PARITY_EN
          state_d = S_PARITY;
          sout_d  = parity_q;
`else
          state_d  = S_IDLE;
          svalid_d = 1'b0;
          sout_d   = IDLE_LEVEL;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        state_d  = S_IDLE;
        svalid_d = 1'b0;
        sout_d   = IDLE_LEVEL;
        fstart_d = 1'b0;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A load overrides end-of-frame handling, giving zero-gap streaming.
    if (xfer) begin
      state_d  = S_SHIFT;
      cnt_d    = '0;
      shadow_d = data_in[WIDTH-2:0];
      sout_d   = data_in[WIDTH-1];
      svalid_d = 1'b1;
      fstart_d = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d = ^data_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      sout_q   <= IDLE_LEVEL;
      svalid_q <= 1'b0;
      fstart_q <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      fstart_q <= fstart_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign serial_out   = sout_q;
  assign serial_valid = svalid_q;
  assign frame_start  = fstart_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized self-checking bench for piso_serializer (WIDTH=4).
module tb_piso_serializer;

  localparam int   W    = 4;
  localparam logic IDLE = 1'b0;
`ifdef PISO_PARITY_EN
  localparam int   FLEN = W + 1;
`else
  localparam int   FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected serial stream: one entry per future valid bit.
  logic mq_bit[$];
  logic mq_first[$];
  logic ready_exp;
  logic e_so, e_sv, e_fs;

  // Downstream 4-bit shift register fed by serial_out.
  logic [3:0] sr;

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sr <= {sr[2:0], serial_out};

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      mq_bit.push_back(w[i]);
      mq_first.push_back(i == W - 1);
    end
`ifdef PISO_PARITY_EN
    mq_bit.push_back(^w);
    mq_first.push_back(1'b0);
`endif
  endtask

  // Apply inputs for one edge and advance the reference stream.
  task automatic drive_step(input logic v, input logic [W-1:0] d);
    data_valid = v;
    data_in    = d;
    if (v && ready_exp) push_word(d);
    @(posedge clk);
    #1;
    if (mq_bit.size() > 0) begin
      e_so      = mq_bit.pop_front();
      e_fs      = mq_first.pop_front();
      e_sv      = 1'b1;
      ready_exp = (mq_bit.size() == 0);
    end else begin
      e_so      = IDLE;
      e_fs      = 1'b0;
      e_sv      = 1'b0;
      ready_exp = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({serial_out, serial_valid, frame_start, busy, data_ready} !== {IDLE, 4'b0001}) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got so/sv/fs/busy/rdy=%b expected %b", i,
                 {serial_out, serial_valid, frame_start, busy, data_ready}, {IDLE, 4'b0001});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_step(1'b0, '0);
      n_cmp++;
      if ({serial_out, serial_valid, frame_start, busy, data_ready} !== {e_so, e_sv, e_fs, e_sv, ready_exp}) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got so/sv/fs/busy/rdy=%b expected %b", i,
                 {serial_out, serial_valid, frame_start, busy, data_ready}, {e_so, e_sv, e_fs, e_sv, ready_exp});
      end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] got;
    got = '0;
    for (int i = 0; i < FLEN + 2; i++) begin
      drive_step(i == 0, 4'b1011);
      if (i < W) got = {got[W-2:0], serial_out};
      n_cmp++;
      if ({serial_out, serial_valid, frame_start, busy, data_ready} !== {e_so, e_sv, e_fs, e_sv, ready_exp}) begin
        n_fail++;
        $display("FAIL single cyc=%0d got so/sv/fs/busy/rdy=%b expected %b", i,
                 {serial_out, serial_valid, frame_start, busy, data_ready}, {e_so, e_sv, e_fs, e_sv, ready_exp});
      end
      if (i == W) begin
        n_cmp++;
        if (sr !== 4'b1011) begin
          n_fail++;
          $display("FAIL single_downstream got sr=%b expected 1011", sr);
        end
      end
    end
    n_cmp++;
    if (got !== 4'b1011) begin
      n_fail++;
      $display("FAIL single_bits got %b expected 1011", got);
    end
    n_cmp++;
    if ({serial_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_end got sv/busy=%b expected 00", {serial_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [2];
    int idx;
    int nvalid;
    words[0] = 4'b1100;
    words[1] = 4'b0011;
    idx = 0;
    nvalid = 0;
    for (int i = 0; i < 2 * FLEN + 2; i++) begin
      logic v;
      logic acc;
      v   = (idx < 2);
      acc = v && ready_exp;
      drive_step(v, words[idx < 2 ? idx : 1]);
      if (acc) idx++;
      if (serial_valid) nvalid++;
      n_cmp++;
      if ({serial_out, serial_valid, frame_start, busy, data_ready} !== {e_so, e_sv, e_fs, e_sv, ready_exp}) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got so/sv/fs/busy/rdy=%b expected %b", i,
                 {serial_out, serial_valid, frame_start, busy, data_ready}, {e_so, e_sv, e_fs, e_sv, ready_exp});
      end
    end
    n_cmp++;
    if (nvalid !== 2 * FLEN) begin
      n_fail++;
      $display("FAIL b2b_count got %0d valid bits expected %0d", nvalid, 2 * FLEN);
    end
  endtask

  task automatic test_stall();
    logic accepted;
    accepted = 1'b0;
    for (int i = 0; i < 2 * FLEN + 3; i++) begin
      logic v;
      logic acc;
      v   = (i == 0) || (!accepted);
      acc = (i != 0) && v && ready_exp;
      drive_step(v, (i == 0) ? 4'b0110 : 4'hF);
      if (acc) accepted = 1'b1;
      n_cmp++;
      if ({serial_out, serial_valid, frame_start, busy, data_ready} !== {e_so, e_sv, e_fs, e_sv, ready_exp}) begin
        n_fail++;
        $display("FAIL stall cyc=%0d got so/sv/fs/busy/rdy=%b expected %b", i,
                 {serial_out, serial_valid, frame_start, busy, data_ready}, {e_so, e_sv, e_fs, e_sv, ready_exp});
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    for (int i = 0; i < 3; i++) drive_step(i == 0, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({serial_out, serial_valid, frame_start, busy, data_ready} !== {IDLE, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_async got so/sv/fs/busy/rdy=%b expected %b",
               {serial_out, serial_valid, frame_start, busy, data_ready}, {IDLE, 4'b0001});
    end
    mq_bit.delete();
    mq_first.delete();
    ready_exp = 1'b1;
    #2;
    rst_n = 1'b1;
    w = W'($urandom);
    for (int i = 0; i < FLEN + 2; i++) begin
      drive_step(i == 0, w);
      n_cmp++;
      if ({serial_out, serial_valid, frame_start, busy, data_ready} !== {e_so, e_sv, e_fs, e_sv, ready_exp}) begin
        n_fail++;
        $display("FAIL reset_restart cyc=%0d got so/sv/fs/busy/rdy=%b expected %b", i,
                 {serial_out, serial_valid, frame_start, busy, data_ready}, {e_so, e_sv, e_fs, e_sv, ready_exp});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_step($urandom_range(0, 3) != 0, W'($urandom));
      n_cmp++;
      if ({serial_out, serial_valid, frame_start, busy, data_ready} !== {e_so, e_sv, e_fs, e_sv, ready_exp}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got so/sv/fs/busy/rdy=%b expected %b", i,
                 {serial_out, serial_valid, frame_start, busy, data_ready}, {e_so, e_sv, e_fs, e_sv, ready_exp});
      end
    end
    for (int i = 0; i < FLEN + 1; i++) drive_step(1'b0, '0);
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words [2];
    logic [W:0]   exp_bits [2];
    words[0] = 4'b1011;
    exp_bits[0] = 5'b10111;
    words[1] = 4'b1001;
    exp_bits[1] = 5'b10010;
    for (int k = 0; k < 2; k++) begin
      logic [W:0] got;
      int nv;
      got = '0;
      nv = 0;
      for (int i = 0; i < FLEN + 1; i++) begin
        drive_step(i == 0, words[k]);
        if (i < FLEN) begin
          got = {got[W-1:0], serial_out};
          if (serial_valid) nv++;
        end
      end
      n_cmp++;
      if (got !== exp_bits[k] || nv != FLEN) begin
        n_fail++;
        $display("FAIL parity word=%b got bits=%b valid=%0d expected bits=%b valid=%0d",
                 words[k], got, nv, exp_bits[k], FLEN);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    ready_exp = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    test_random();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage that sits directly upstream of the 4-bit serial shift register and drives its serial `in` input. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, MSB first, with a qualifying strobe and a frame-start marker. Back-to-back words stream with no idle gap, so the downstream shift register holds a complete word every WIDTH cycles.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- IDLE_LEVEL, 1'b0, value driven on serial_out when no frame is active.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- data_in, input, WIDTH, parallel word; sampled only on handshake.
- data_valid, input, 1, upstream has a word on data_in.
- data_ready, output, 1, serializer accepts a word on this edge.
- serial_out, output, 1, serial bit stream; connects to the shift register `in`.
- serial_valid, output, 1, serial_out carries a frame bit this cycle.
- frame_start, output, 1, high during the first bit of each frame.
- busy, output, 1, frame in progress (state != IDLE).

Behaviour:
- Reset (rst_n low, asynchronous, any time): state=IDLE, bit counter=0, shadow register=0, serial_out=IDLE_LEVEL, serial_valid=0, frame_start=0. The word in flight is discarded. Release is synchronous to the next clk edge.
- serial_out, serial_valid and frame_start are registered outputs. data_ready is combinational from state and counter only; it never depends on data_valid.
- States: IDLE, SHIFT, PARITY. PARITY exists only when the optional feature is enabled.
- Handshake: a transfer occurs on an edge where data_valid && data_ready. data_in is ignored on every other edge, including while data_valid is high and data_ready is low.
- data_ready is high in IDLE. It is also high in the cycle that outputs the final frame bit: bit WIDTH-1 without parity, or the parity bit with parity enabled.
- On a transfer at edge N, the following happens:
  - serial_out <= data_in[WIDTH-1]
  - shadow <= data_in[WIDTH-2:0]
  - counter <= 0
  - serial_valid <= 1
  - frame_start <= 1
  - state <= SHIFT
  - Bit k (MSB first) is therefore visible in the cycle after edge N+k. Latency from handshake to first bit is 1 cycle.
- SHIFT, each edge with counter < WIDTH-1:
  - serial_out <= shadow MSB
  - shadow shifts left
  - counter increments
  - frame_start <= 0
- End of frame (counter == WIDTH-1, no parity):
  - If a transfer occurs on this edge, the next word loads immediately (zero-gap streaming) and frame_start pulses again.
  - Otherwise: state <= IDLE, serial_valid <= 0, serial_out <= IDLE_LEVEL.
- Counter width is $clog2(WIDTH). It never wraps past WIDTH-1.
- busy = (state != IDLE). It stays high across back-to-back frames.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: after bit WIDTH-1 the block enters PARITY for one cycle.
  - serial_out = even parity of the word (XOR of all WIDTH bits), serial_valid=1, frame_start=0.
  - data_ready is high only in IDLE and PARITY, not on the last data bit.
  - Frame length is WIDTH+1 cycles.
  - The parity value is computed at load and stored, so it does not depend on the shadow after shifting.
- Not defined: no PARITY state, no parity storage, frame length is WIDTH cycles, and data_ready rules are as in Behaviour.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then 1, data_valid=0 for 8 cycles. Required: serial_out=0, serial_valid=0, frame_start=0, busy=0, data_ready=1 throughout.
- Single word: WIDTH=4, data_in=4'b1011 with a one-cycle valid. Required:
  - serial_out reads 1,0,1,1 on the 4 cycles after the handshake, serial_valid=1 and frame_start=1 only on the first.
  - Downstream shift register `out`=4'b1011 after the 4th bit is clocked in.
  - Then serial_valid=0 and busy=0.
- Back-to-back: 4'b1100 then 4'b0011 with data_valid held high. Required:
  - 8 consecutive valid bits 1,1,0,0,0,0,1,1, no gap cycle.
  - frame_start high on bits 0 and 4.
  - data_ready high only on the cycle carrying bit 3.
- Stall: data_valid=1 while busy, data_in changed to 4'hF mid-frame. Required: the in-flight frame is unchanged, and 4'hF is accepted only when data_ready=1.
- Reset mid-frame: rst_n pulsed low between clock edges during bit 2 of 4'b1010. Required:
  - Outputs clear immediately (serial_valid=0, serial_out=0, busy=0), without waiting for a clock edge.
  - The next accepted word starts cleanly at bit 0.
- Parity (PISO_PARITY_EN): 4'b1011. Required:
  - Sequence 1,0,1,1 then parity bit 1, all 5 cycles with serial_valid=1.
  - For 4'b1001 the parity bit is 0.
